rr_mux_arbiter: RTL
===================

# rr_mux_arbiter

Round-robin arbiter that shares the single registered mux/flop datapath in `top` among `N_REQ` requesters. Each requester raises a request. The block grants exactly one requester at a time and drives the datapath select index. It bounds each grant to `MAX_HOLD` cycles and inserts `GAP` idle cycles between owners. It sits in front of the shared mux and flop and is the only driver of their select.

## Interface
- `N_REQ`, 4, number of requesters; legal range ≥ 2.
- `MAX_HOLD`, 8, maximum consecutive cycles one owner keeps the grant; legal range ≥ 1.
- `GAP`, 1, idle cycles with no grant between two grants; legal range ≥ 0.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input `N_REQ`: per-requester request level.
- `gnt` output `N_REQ`: one-hot grant; all zeros when nobody is granted.
- `gnt_valid` output 1: equals the OR-reduction of `gnt`.
- `sel` output `$clog2(N_REQ)`: binary index of the current owner; holds its last value when no grant is active.
- `hold_cnt` output `$clog2(MAX_HOLD)` (minimum 1 bit): number of cycles the current owner has held the grant, minus 1.
- `busy` output 1: high in the GRANT and GAP states.

## Operation
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If `|req` is true, pick the winner with `rr_pick(req, ptr)`, then go to GRANT, load `gnt`/`sel`, and clear `hold_cnt`.
- GRANT:
  - Release condition: `req[sel]==0`, or `hold_cnt==MAX_HOLD-1`.
  - On release, `ptr` becomes `sel+1` modulo `N_REQ`.
  - On release with `GAP>0`: go to GAP and clear `gnt`.
  - On release with `GAP==0`: arbitrate in the same edge. Go to GRANT with the new winner if any `req` is high (the departing owner has lowest priority), otherwise go to IDLE.
  - No release: increment `hold_cnt`.
- GAP:
  - Count `GAP` cycles with `gnt=0`, then arbitrate exactly as in IDLE.
- Round-robin pointer `ptr`:
  - Resets to 0.
  - Priority is `ptr`, `ptr+1`, … wrapping modulo `N_REQ`.
- Forced rotation: a lone requester still rotates out at `MAX_HOLD`. It wins again after GAP.
- Request changes:
  - Requests from non-owners never affect the current grant.
  - A new `req` arriving in GAP is considered only at the arbitration edge.
- Reset while `rst_n` is low, regardless of state: `gnt=0`, `gnt_valid=0`, `sel=0`, `hold_cnt=0`, `busy=0`, state IDLE, `ptr=0`.

## Timing
- All outputs are registered.
- Grant latency: `req` high in cycle t while IDLE → `gnt` high in cycle t+1.
- Release latency: the owner drops `req` in cycle t → `gnt` low in cycle t+1. The grant overlaps the dropped request by one cycle; requesters tolerate this.
- Maximum hold: `gnt` is high for exactly `MAX_HOLD` cycles when `req` stays high.
- Between owners there are exactly `GAP` cycles with `gnt=0`. With `GAP=0`, the hand-off is back-to-back with no gap.
- Reset assertion is asynchronous; outputs clear without waiting for a clock edge. Deassertion is synchronized upstream. The first arbitration happens on the first edge after deassertion.
- Worst-case wait for any requester that holds `req` high: `(N_REQ-1)*(MAX_HOLD+GAP)+GAP+1` cycles.

## Structure
- Package `rr_arb_pkg`:
  - state enum `arb_state_e` {IDLE, GRANT, GAP};
  - default parameter constants;
  - function `idx_to_onehot`.
- Sub-module `rr_pick`:
  - purely combinational masked priority picker;
  - inputs `req`, `ptr`; outputs winner index and `found`;
  - implemented as a double-width mask and find-first.
- The FSM, counters and output registers live in `rr_mux_arbiter`.

## Test plan
All scenarios use `N_REQ=4`, `MAX_HOLD=8`, `GAP=1` unless stated.
- Reset: after power-up with `rst_n=0` and `req=4'b1111` → all outputs are 0; first grant is `gnt=4'b0001` one cycle after release.
- Single request: `req=4'b0100` for cycles 0–2, then 0 → `gnt=4'b0100`, `sel=2` in cycles 1–3, `gnt=0` from cycle 4.
- All requesting: `req=4'b1111` held → owners 0, 1, 2, 3, 0; each holds 8 cycles (`hold_cnt` 0..7) with a 1-cycle `gnt=0` gap between them.
- Early release: `req=4'b1010`; owner 1 drops after 2 cycles → next grant is 3, then 1 again once `req[1]` returns.
- `GAP=0` instance with `req=4'b0011` → grants alternate 0/1 every 8 cycles; `gnt_valid` never drops.
- Mid-grant reset: pulse `rst_n` low asynchronously during grant 2 → `gnt=0` immediately; the next grant after release goes to requester 0 if requesting.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin mux arbiter.
package rr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_MAX_HOLD = 8;
   localparam int DEF_GAP      = 1;

   // Widest requester count the one-hot helper supports; callers truncate.
   localparam int ONEHOT_W = 32;

   function automatic logic [ONEHOT_W-1:0] idx_to_onehot(input logic [4:0] idx);
      return {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter  int N_REQ = rr_arb_pkg::DEF_N_REQ,
   localparam int SW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SW-1:0]    ptr,
   output logic [SW-1:0]    idx,
   output logic             found
);

   logic [2*N_REQ-1:0] dbl;

   // Unroll req twice, mask off everything below ptr, then find the lowest set bit.
   always_comb begin
      dbl   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < 2*N_REQ; i++)
         dbl[i] = (i >= int'(ptr)) && req[i % N_REQ];
      for (int i = 2*N_REQ-1; i >= 0; i--) begin
         if (dbl[i]) begin
            found = 1'b1;
            idx   = SW'(i % N_REQ);
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of the shared mux/flop datapath.
// Grants are capped at MAX_HOLD cycles and separated by GAP idle cycles.
module rr_mux_arbiter #(
   parameter  int N_REQ    = rr_arb_pkg::DEF_N_REQ,
   parameter  int MAX_HOLD = rr_arb_pkg::DEF_MAX_HOLD,
   parameter  int GAP      = rr_arb_pkg::DEF_GAP,
   localparam int SW       = $clog2(N_REQ),
   localparam int HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [SW-1:0]    sel,
   output logic [HW-1:0]    hold_cnt,
   output logic             busy
);

   import rr_arb_pkg::*;

   // Inside this module the name GAP is the parameter; the GAP state is
   // always written fully qualified as rr_arb_pkg::GAP.
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   arb_state_e    state;
   logic [SW-1:0] ptr;
   logic [SW-1:0] sel_inc;
   logic [SW-1:0] arb_ptr;
   logic [SW-1:0] win;
   logic          found;
   logic [GW-1:0] gap_cnt;
   logic          release_now;
   logic          do_arb;

   assign sel_inc     = (sel == SW'(N_REQ-1)) ? '0 : sel + SW'(1);
   assign release_now = !req[sel] || (hold_cnt == HW'(MAX_HOLD-1));

   // A zero-gap hand-off arbitrates on the release edge, so it must already
   // see the rotated pointer (departing owner last) before ptr is written.
   assign arb_ptr = (state == GRANT) ? sel_inc : ptr;

   assign do_arb = (state == IDLE)
                || ((state == GRANT) && release_now && (GAP == 0))
                || ((state == rr_arb_pkg::GAP) && (gap_cnt == GW'(GAP-1)));

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req),
      .ptr   (arb_ptr),
      .idx   (win),
      .found (found)
   );

   // Arbiter FSM with registered grant, select, hold counter and busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         sel       <= '0;
         hold_cnt  <= '0;
         busy      <= 1'b0;
         gap_cnt   <= '0;
      end else begin
         if (do_arb) begin
            if (found) begin
               state     <= GRANT;
               gnt       <= N_REQ'(idx_to_onehot(5'(win)));
               gnt_valid <= 1'b1;
               sel       <= win;
               hold_cnt  <= '0;
               busy      <= 1'b1;
            end else begin
               state     <= IDLE;
               gnt       <= '0;
               gnt_valid <= 1'b0;
               busy      <= 1'b0;
            end
         end else if (state == GRANT) begin
            if (release_now) begin
               // only reached with GAP > 0; zero-gap release is handled by do_arb
               state     <= rr_arb_pkg::GAP;
               gnt       <= '0;
               gnt_valid <= 1'b0;
               gap_cnt   <= '0;
            end else begin
               hold_cnt <= hold_cnt + HW'(1);
            end
         end else if (state == rr_arb_pkg::GAP) begin
            gap_cnt <= gap_cnt + GW'(1);
         end else begin
            // unused encoding: recover to IDLE
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
         end

         if ((state == GRANT) && release_now)
            ptr <= sel_inc;
      end
   end

endmodule
